// File: rtl/grf_pkg.sv
// Shared constants and types for the general register file with pending-write scoreboard.
package grf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int PEND_W_DEF = 2;

  // Architectural zero register: reads as 0, never written, never pending.
  localparam int REG_ZERO = 0;

  typedef logic [PEND_W_DEF-1:0] pend_cnt_t;

endpackage

// File: rtl/grf_read_port.sv
// One read port: zero-register check, optional W->D bypass mux and ready flag.
module grf_read_port
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              cnt_zero,
  input  logic              cnt_one,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ready
);

  logic is_zero;
  logic hit;

  // Select register-zero constant, bypassed W data or array data; a forwarded
  // write only makes the operand final when it is the last one outstanding.
  always_comb begin
    is_zero = (rd_addr == ADDR_W'(REG_ZERO));
    hit     = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
    if (is_zero) begin
      rd_data = '0;
    end else if (hit) begin
      rd_data = wr_data;
    end else begin
      rd_data = rf_data;
    end
    rd_ready = is_zero || cnt_zero || (hit && cnt_one);
  end

endmodule

// File: rtl/grf_scoreboard.sv
// General register file with N read ports, W-stage bypass and per-register
// pending-write counters feeding the hazard unit.
//
// Issue handshake: issue_en is the valid, issue_ready the ready; an issue is
// accepted (counter incremented) only in a cycle where both are high.
// issue_ready does not depend on issue_en, and a refused issue has no effect,
// so the hazard unit must hold the instruction upstream until ready.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_use,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  output logic                     stall,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  output logic                     err_underflow
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] rf_q  [NUM_REGS];
  logic [DATA_W-1:0] rf_d  [NUM_REGS];
  logic [PEND_W-1:0] cnt_q [NUM_REGS];
  logic [PEND_W-1:0] cnt_d [NUM_REGS];
  logic              err_q;
  logic              err_d;

  logic                wr_act;
  logic                issue_acc;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  assign wr_act      = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
  assign issue_ready = (issue_addr == ADDR_W'(REG_ZERO)) || (cnt_q[issue_addr] != CNT_MAX);
  assign issue_acc   = issue_en && issue_ready && (issue_addr != ADDR_W'(REG_ZERO));

  // One-hot increment/decrement requests; register 0 never takes part.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_acc) inc_vec[issue_addr] = 1'b1;
    if (wr_act)    dec_vec[wr_addr]    = 1'b1;
  end

  // Next array contents, counters and sticky underflow flag.
  always_comb begin
    rf_d  = rf_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (wr_act) rf_d[wr_addr] = wr_data;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + PEND_W'(1);
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - PEND_W'(1);
        end
      end
    end
  end

  // State registers; reset overrides any same-cycle write or issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q  <= '{default: '0};
      cnt_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      rf_q  <= rf_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_underflow = err_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_i;
    logic              cnt_zero_i;
    logic              cnt_one_i;

    assign addr_i     = rd_addr[i*ADDR_W +: ADDR_W];
    assign cnt_zero_i = (cnt_q[addr_i] == '0);
    assign cnt_one_i  = (cnt_q[addr_i] == PEND_W'(1));

    grf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_port (
      .rd_addr  (addr_i),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rf_data  (rf_q[addr_i]),
      .cnt_zero (cnt_zero_i),
      .cnt_one  (cnt_one_i),
      .rd_data  (rd_data[i*DATA_W +: DATA_W]),
      .rd_ready (rd_ready[i])
    );
  end

  assign stall = |(rd_use & ~rd_ready);

endmodule
